// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: RV32I funct3 encodings,
// FSM state encoding and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Loads accept B/H/W/BU/HU; stores only B/H/W.
  function automatic logic legal_f3(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned address.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bundles the pipeline request/response handshake and the data-memory port.
// slave = controller view, master = pipeline/memory (testbench) view.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_wd, mem_we
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/lsu_align.sv
// Purely combinational byte-lane logic: load extract + sign/zero extend,
// and sub-word store merge into the previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  // Pick the addressed byte/half and extend it according to funct3.
  always_comb begin
    byte_sel  = word[{off, 3'b000} +: 8];
    half_sel  = off[1] ? word[31:16] : word[15:0];
    load_data = '0;
    case (f3)
      F3_B:    load_data = 32'(byte_sel);
      F3_H:    load_data = 32'(half_sel);
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Replace only the addressed lane of the old word; full words pass through.
  always_comb begin
    merge_data = word;
    case (f3)
      F3_B:    merge_data[{off, 3'b000} +: 8]        = wdata[7:0];
      F3_H:    merge_data[{off[1], 4'b0000} +: 16]   = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the pipeline memory stage and a word-wide
// data memory. Sub-word stores are done as read-modify-write.
// Optional build macro: LSU_RANGE_CHECK_EN -- flag addresses outside the
// attached memory as errors instead of wrapping the word index.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_ctrl_if.slave bus
);

  state_t      state, next_state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        range_err;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

`ifdef LSU_RANGE_CHECK_EN
  assign range_err = (bus.req_addr[31:AW+2] != '0) ||
                     (32'(bus.req_addr[AW+1:2]) >= 32'(DEPTH));
`else
  // Upper address bits are ignored; the index wraps modulo 2^AW.
  localparam int unused_depth = DEPTH;
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];
  assign range_err      = 1'b0;
`endif

  assign accept  = (state == IDLE) && rst && bus.req_valid;
  assign req_err = !legal_f3(bus.req_store, bus.req_funct3) ||
                   misaligned(bus.req_funct3, bus.req_addr[1:0]) || range_err;

  lsu_align u_align (
    .word       (bus.mem_rd),
    .off        (addr_q[1:0]),
    .f3         (f3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign bus.req_ready = (state == IDLE) && rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_a     = (state != IDLE) ? {{(32-AW){1'b0}}, addr_q[AW+1:2]} : 32'h0;
  assign bus.mem_wd    = (state == WRITE) ? merged_q : 32'h0;
  // Gated with rst so a reset edge can never commit a write.
  assign bus.mem_we    = (state == WRITE) && rst;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                    next_state = RESP;
          else if (!bus.req_store)        next_state = LOAD;
          else if (bus.req_funct3 == F3_W) next_state = WRITE;
          else                            next_state = RMW_RD;
        end
      end
      LOAD:    next_state = RESP;
      RMW_RD:  next_state = WRITE;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latches, merged store word and response registers; the response
  // registers only change on the edge into RESP so they hold between responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      store_q  <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            store_q  <= bus.req_store;
            f3_q     <= bus.req_funct3;
            addr_q   <= bus.req_addr[AW+1:0];
            wdata_q  <= bus.req_wdata;
            merged_q <= bus.req_wdata;
            if (req_err) begin
              rdata_q <= 32'h0;
              err_q   <= 1'b1;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_data;
          err_q   <= 1'b0;
        end
        RMW_RD: merged_q <= merge_data;
        WRITE: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed scoreboard bench for lsu_mem_ctrl with a behavioural word memory.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0]   mem [DEPTH];
  logic          bd_we   = 1'b0;
  logic [AW-1:0] bd_idx  = '0;
  logic [31:0]   bd_data = 32'h0;

  assign bus.mem_rd = mem[bus.mem_a[AW-1:0]];

  always @(posedge clk) begin
    if (bd_we)           mem[bd_idx] <= bd_data;
    else if (bus.mem_we) mem[bus.mem_a[AW-1:0]] <= bus.mem_wd;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = AW'(idx);
    bd_data = data;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic issue(input string tag, input logic store, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int exp_we);
    int   lat, we_cnt, we_at, guard;
    exp_t e;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = store;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    @(negedge clk);
    // Scramble the request bus after acceptance: the controller must use its latches.
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 1; we_cnt = 0; we_at = 0;
    while (!bus.rsp_valid && lat < 10) begin
      if (bus.mem_we) begin
        we_cnt++;
        we_at = lat;
      end
      @(negedge clk);
      lat++;
    end
    if (bus.mem_we) we_cnt++;
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (bus.rsp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
      check({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
    end
    check({tag, "_we_pulses"}, 32'(we_cnt), 32'(exp_we));
    if (exp_we > 0) check({tag, "_we_cycle"}, 32'(we_at), 32'(exp_lat - 1));
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_rdata_hold"}, bus.rsp_rdata, exp_rdata);
    check({tag, "_err_hold"}, 32'(bus.rsp_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int rsp_seen;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // Reset phase, clearing the memory model while rst is low.
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) poke(i, 32'h0);
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("rst_mem_we",    32'(bus.mem_we), 32'd0);
    check("rst_mem_a",     bus.mem_a, 32'h0);
    check("rst_mem_wd",    bus.mem_wd, 32'h0);
    check("rst_ready_low", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_ready_high", 32'(bus.req_ready), 32'd1);

    poke(0, 32'h01234567);
    poke(1, 32'h8899AABB);
    poke(2, 32'h11223344);

    // Loads with sign/zero extension.
    issue("lb_7",   1'b0, F3_B,  32'h7, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0);
    issue("lbu_4",  1'b0, F3_BU, 32'h4, 32'h0, 32'h000000BB, 1'b0, 2, 0);
    issue("lh_6",   1'b0, F3_H,  32'h6, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
    issue("lhu_4",  1'b0, F3_HU, 32'h4, 32'h0, 32'h0000AABB, 1'b0, 2, 0);

    // Sub-word stores (read-modify-write) and full-word store.
    issue("sh_a",   1'b1, F3_H,  32'hA, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1);
    check("sh_a_mem2", mem[2], 32'hBEEF3344);
    issue("sb_9",   1'b1, F3_B,  32'h9, 32'h12345655, 32'h0, 1'b0, 3, 1);
    check("sb_9_mem2", mem[2], 32'hBEEF5544);
    issue("sw_10",  1'b1, F3_W,  32'h10, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1);
    check("sw_10_mem4", mem[4], 32'hCAFEF00D);
    issue("lw_10",  1'b0, F3_W,  32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0);

    // Error paths: misalignment and illegal funct3.
    issue("lw_6_mis",  1'b0, F3_W,   32'h6, 32'h0, 32'h0, 1'b1, 1, 0);
    issue("sh_3_mis",  1'b1, F3_H,   32'h3, 32'hFFFF, 32'h0, 1'b1, 1, 0);
    check("sh_3_mem0", mem[0], 32'h01234567);
    issue("ld_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
    issue("st_f3_100", 1'b1, F3_BU,  32'h0, 32'h55, 32'h0, 1'b1, 1, 0);
    check("st_f3_100_mem0", mem[0], 32'h01234567);

    // Out-of-range address.
`ifdef LSU_RANGE_CHECK_EN
    issue("lw_80_range", 1'b0, F3_W, 32'h80, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    issue("lw_80_wrap",  1'b0, F3_W, 32'h80, 32'h0, 32'h01234567, 1'b0, 2, 0);
`endif

    // Reset while an SB is in WRITE: the write must be dropped.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h5;
    bus.req_wdata  = 32'h77;
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid_rst_rmw_a", bus.mem_a, 32'h1);
    @(negedge clk);
    check("mid_rst_write_we", 32'(bus.mem_we), 32'd1);
    check("mid_rst_write_wd", bus.mem_wd, 32'h8899779B & 32'hFFFF77FF | 32'h00007700 & 32'h00007700 | (32'h8899AABB & 32'hFFFF00FF));
    rst = 1'b0;
    #1;
    check("mid_rst_we_gated", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    check("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_idle_a", bus.mem_a, 32'h0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready_back", 32'(bus.req_ready), 32'd1);
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen++;
    end
    check("mid_rst_rsp_count", 32'(rsp_seen), 32'd0);
    check("mid_rst_mem1", mem[1], 32'h8899AABB);

    // Controller is fully usable afterwards.
    issue("lw_4_after", 1'b0, F3_W, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
